data_mem_pipe: RTL

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 33 +++
 rtl/data_mem_pipe.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared FSM state type, default geometry/latency and address helper for data_mem_pipe.
// Byte-lane writes are selected by macro DMEM_BYTE_WRITE_EN (see data_mem_pipe).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_LAT    = 2;

  // Number of low address bits that select a byte within one data word.
  function automatic int byte_off_w(input int data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for data_mem_pipe: synchronous write with per-byte-lane enables, combinational read.
// Deliberately has no reset so contents survive a block reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/data_mem_pipe.sv
// Single-outstanding data memory: IDLE -> (WAIT) -> RESP, one-cycle response LAT cycles after accept.
// Macro DMEM_BYTE_WRITE_EN: honour req_be per byte lane; when undefined every write updates the full word.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LAT    = DEF_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = byte_off_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              accept;
  logic              commit;
  logic              in_err;
  logic [31:0]       in_word;
  logic              cur_we;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [NB-1:0]     cur_be;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] resp_rdata_d;
  logic              wr_en;

  assign in_word = req_addr >> OFF_W;
  assign in_err  = ((req_addr & 32'(NB - 1)) != 32'd0) || (in_word >= 32'(DEPTH));

  always_comb begin
    accept = req_valid && (state_q == IDLE);
    // With LAT = 1 the commit edge is the accept edge, so the live request drives the array.
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_err   = in_err;
      cur_idx   = in_word[IDX_W-1:0];
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_err   = err_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    commit       = (LAT == 1) ? accept : ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
    resp_rdata_d = (commit && !cur_we && !cur_err) ? rd_data : '0;
  end

`ifdef DMEM_BYTE_WRITE_EN
  assign wr_be = cur_be;
`else
  logic be_unused;
  assign be_unused = ^cur_be;
  assign wr_be     = '1;
`endif

  // A reset on the commit edge aborts the request, so it also blocks the array write.
  assign wr_en = commit && cur_we && !cur_err && !rst;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_idx_i  (cur_idx),
    .wr_be_i   (wr_be),
    .wr_data_i (cur_wdata),
    .rd_idx_i  (cur_idx),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= commit;
      resp_err_q   <= commit && cur_err;
      resp_rdata_q <= resp_rdata_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            err_q   <= in_err;
            idx_q   <= in_word[IDX_W-1:0];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LAT == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(LAT - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
